// File: rtl/walk_request_register.sv
// Sticky pedestrian walk-request latches for two crossings; a flag sets one cycle after its button rises.
// No backpressure: a flag stays set until WR_Reset clears both channels, and a concurrent new press wins.
module walk_request_register (
   input  logic clk,
   input  logic g_reset,
   input  logic WR_Sync_1,
   input  logic WR_Sync_2,
   input  logic WR_Reset,
   output logic WR_Out_1,
   output logic WR_Out_2
);

   logic [1:0] sync;
   logic [1:0] prev;
   logic [1:0] req;
   logic [1:0] rise;

   assign sync = {WR_Sync_2, WR_Sync_1};
   assign rise = sync & ~prev;

   // prev clears on reset so a button held across reset counts as a fresh press.
   always_ff @(posedge clk) begin
      if (!g_reset) begin
         req  <= 2'b00;
         prev <= 2'b00;
      end else begin
         prev <= sync;
         req  <= rise | (req & {2{~WR_Reset}});
      end
   end

   assign WR_Out_1 = req[0];
   assign WR_Out_2 = req[1];

endmodule

// File: tb/tb_walk_request_register.sv
// Testbench for walk_request_register: directed scenarios plus randomized traffic against a reference model.
module tb_walk_request_register;

   logic clk = 1'b0;
   logic g_reset = 1'b0;
   logic WR_Sync_1 = 1'b0;
   logic WR_Sync_2 = 1'b0;
   logic WR_Reset = 1'b0;
   logic WR_Out_1;
   logic WR_Out_2;

   int checks = 0;
   int errors = 0;

   // Reference model: one pending-request bit and one last-seen button level per crossing.
   bit m_pending [2];
   bit m_level   [2];

   walk_request_register dut (
      .clk      (clk),
      .g_reset  (g_reset),
      .WR_Sync_1(WR_Sync_1),
      .WR_Sync_2(WR_Sync_2),
      .WR_Reset (WR_Reset),
      .WR_Out_1 (WR_Out_1),
      .WR_Out_2 (WR_Out_2)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs on the falling edge, advance the model at the rising edge, return 1 ns later.
   task automatic tick(input logic g, input logic s1, input logic s2, input logic r);
      bit btn [2];
      @(negedge clk);
      g_reset = g; WR_Sync_1 = s1; WR_Sync_2 = s2; WR_Reset = r;
      @(posedge clk);
      btn[0] = s1;
      btn[1] = s2;
      for (int n = 0; n < 2; n++) begin
         if (!g) begin
            m_pending[n] = 1'b0;
            m_level[n]   = 1'b0;
         end else begin
            if (btn[n] && !m_level[n])
               m_pending[n] = 1'b1;
            else if (r)
               m_pending[n] = 1'b0;
            m_level[n] = btn[n];
         end
      end
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %b%b want 00", i, WR_Out_1, WR_Out_2);
         end
      end
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_held: got %b%b want 11", WR_Out_1, WR_Out_2);
      end
   endtask

   task automatic test_set_hold;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
         errors++;
         $display("FAIL set_idle: got %b%b want 00", WR_Out_1, WR_Out_2);
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b10) begin
         errors++;
         $display("FAIL set_latency: got %b%b want 10", WR_Out_1, WR_Out_2);
      end
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b10) begin
            errors++;
            $display("FAIL set_hold cycle %0d: got %b%b want 10", i, WR_Out_1, WR_Out_2);
         end
      end
   endtask

   task automatic test_clear;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b11) begin
         errors++;
         $display("FAIL clear_setup: got %b%b want 11", WR_Out_1, WR_Out_2);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
         errors++;
         $display("FAIL clear_pulse: got %b%b want 00", WR_Out_1, WR_Out_2);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
            errors++;
            $display("FAIL clear_stay cycle %0d: got %b%b want 00", i, WR_Out_1, WR_Out_2);
         end
      end
   endtask

   task automatic test_held_through_clear;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
         errors++;
         $display("FAIL held_clear: got %b%b want 00", WR_Out_1, WR_Out_2);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
            errors++;
            $display("FAIL held_no_reset cycle %0d: got %b%b want 00", i, WR_Out_1, WR_Out_2);
         end
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b01) begin
         errors++;
         $display("FAIL held_repress: got %b%b want 01", WR_Out_1, WR_Out_2);
      end
   endtask

   task automatic test_simultaneous;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b10) begin
         errors++;
         $display("FAIL simultaneous: got %b%b want 10", WR_Out_1, WR_Out_2);
      end
   endtask

   task automatic test_mid_reset;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset cycle %0d: got %b%b want 00", i, WR_Out_1, WR_Out_2);
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_after cycle %0d: got %b%b want 00", i, WR_Out_1, WR_Out_2);
         end
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({WR_Out_1, WR_Out_2} !== 2'b10) begin
         errors++;
         $display("FAIL mid_reset_press: got %b%b want 10", WR_Out_1, WR_Out_2);
      end
   endtask

   task automatic test_random;
      logic g, s1, s2, r;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         g  = ($urandom_range(0, 15) != 0);
         s1 = $urandom_range(0, 1);
         s2 = $urandom_range(0, 1);
         r  = ($urandom_range(0, 5) == 0);
         tick(g, s1, s2, r);
         checks++;
         if ({WR_Out_1, WR_Out_2} !== {m_pending[0], m_pending[1]}) begin
            errors++;
            $display("FAIL random cycle %0d: got %b%b want %b%b", i, WR_Out_1, WR_Out_2,
                     m_pending[0], m_pending[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_hold();
      test_clear();
      test_held_through_clear();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
